// File: rtl/tx_scheduler.sv
// Round-robin arbiter sharing one two-byte serial transmitter among N_REQ requesters.
// Latches the granted word, drives start/data, and acks or aborts via the transmitter's state/done.
module tx_scheduler #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 48
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [16*N_REQ-1:0]  req_data,
    output logic [N_REQ-1:0]     ack,
    output logic                 tx_start,
    output logic [15:0]          tx_data,
    input  logic                 tx_done,
    input  logic [1:0]           tx_state,
    output logic                 busy,
    output logic [2:0]           grant_id,
    output logic                 timeout_err
);
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [2:0]      grant_q, grant_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            start_q, start_d;
    logic [15:0]     data_q, data_d;
    logic            terr_q, terr_d;

    logic            found;
    logic [2:0]      sel;
    logic [2:0]      ptr_next;

    // First asserted request at or above ptr, wrapping modulo N_REQ.
    always_comb begin
        int idx;
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = 3'(idx);
            end
        end
    end

    assign ptr_next = (grant_q == 3'(N_REQ - 1)) ? 3'd0 : grant_q + 3'd1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        start_d = start_q;
        data_d  = data_q;
        terr_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d = sel;
                    data_d  = req_data[16*int'(sel) +: 16];
                    start_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tx_state != 2'd0) begin
                    start_d = 1'b0;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else if (cnt_q == TERM) begin
                    start_d = 1'b0;
                    terr_d  = 1'b1;
                    ptr_d   = ptr_next;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                // Done beats a timeout landing on the same cycle.
                if (tx_done) begin
                    state_d = S_DONE;
                end else if (cnt_q == TERM) begin
                    terr_d  = 1'b1;
                    ptr_d   = ptr_next;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                ptr_d   = ptr_next;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
            start_q <= 1'b0;
            data_q  <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            data_q  <= data_d;
            terr_q  <= terr_d;
        end
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++)
            ack[i] = (state_q == S_DONE) && (grant_q == 3'(i));
    end

    assign tx_start    = start_q;
    assign tx_data     = data_q;
    assign busy        = (state_q != S_IDLE);
    assign grant_id    = grant_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_tx_scheduler.sv
// Directed bench for tx_scheduler with a small behavioural transmitter model
// that can be swapped for hand-forced tx_state/tx_done.
module tb_tx_scheduler;
    localparam int N  = 4;
    localparam int TO = 48;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [16*N-1:0] req_data = '0;
    logic [N-1:0]    ack;
    logic            tx_start;
    logic [15:0]     tx_data;
    logic            tx_done;
    logic [1:0]      tx_state;
    logic            busy;
    logic [2:0]      grant_id;
    logic            timeout_err;

    int errors = 0;
    int checks = 0;

    logic        model_en = 1'b1;
    logic [1:0]  f_state = 2'd0;
    logic        f_done = 1'b0;
    logic [1:0]  m_state = 2'd0;
    logic        m_done = 1'b0;
    logic [15:0] m_sh = '0;
    logic [15:0] m_cap = '0;
    int          m_bit = 0;

    logic [N-1:0] got [8];
    int           ngot;

    always #5 clk = ~clk;

    assign tx_state = model_en ? m_state : f_state;
    assign tx_done  = model_en ? m_done  : f_done;

    tx_scheduler #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack),
        .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done), .tx_state(tx_state),
        .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
    );

    // Transmitter model: START, 16 data bits MSB first, STOP, then a one-cycle done in IDLE.
    always @(posedge clk) begin
        m_done <= 1'b0;
        case (m_state)
            2'd0: if (model_en && tx_start) begin m_state <= 2'd1; m_sh <= tx_data; end
            2'd1: begin m_state <= 2'd2; m_bit <= 0; end
            2'd2: begin
                m_cap <= {m_cap[14:0], m_sh[15]};
                m_sh  <= {m_sh[14:0], 1'b0};
                if (m_bit == 15) m_state <= 2'd3;
                else m_bit <= m_bit + 1;
            end
            default: begin m_state <= 2'd0; m_done <= 1'b1; end
        endcase
    end

    task automatic do_reset();
        req = '0; f_state = 2'd0; f_done = 1'b0;
        rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_acks(input int n, input int budget);
        ngot = 0;
        for (int c = 0; c < budget && ngot < n; c++) begin
            @(negedge clk);
            if (ack != '0) begin got[ngot] = ack; ngot++; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks += 6;
        if (ack !== '0)          begin errors++; $display("FAIL reset_ack got=%b want=0", ack); end
        if (tx_start !== 1'b0)   begin errors++; $display("FAIL reset_tx_start got=%b want=0", tx_start); end
        if (tx_data !== 16'h0)   begin errors++; $display("FAIL reset_tx_data got=%h want=0", tx_data); end
        if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        if (grant_id !== 3'd0)   begin errors++; $display("FAIL reset_grant_id got=%0d want=0", grant_id); end
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got=%b want=0", timeout_err); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic bad;
        logic seen;
        do_reset();
        model_en = 1'b1;
        req_data[15:0] = 16'hA55A;
        req = 4'b0001;
        @(negedge clk);
        checks += 5;
        if (tx_start !== 1'b1) begin errors++; $display("FAIL single_start_hi got=%b want=1", tx_start); end
        if (tx_state !== 2'd0) begin errors++; $display("FAIL single_state_before got=%0d want=0", tx_state); end
        if (grant_id !== 3'd0) begin errors++; $display("FAIL single_grant got=%0d want=0", grant_id); end
        if (busy !== 1'b1)     begin errors++; $display("FAIL single_busy got=%b want=1", busy); end
        if (tx_data !== 16'hA55A) begin errors++; $display("FAIL single_data got=%h want=a55a", tx_data); end
        @(negedge clk);
        checks++;
        if (tx_state !== 2'd1) begin errors++; $display("FAIL single_state_start got=%0d want=1", tx_state); end
        req_data[15:0] = 16'hFFFF;
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b0) begin errors++; $display("FAIL single_start_lo got=%b want=0", tx_start); end
        bad = 1'b0; seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk);
            if (tx_data !== 16'hA55A) bad = 1'b1;
            if (ack != '0) seen = 1'b1;
        end
        checks += 3;
        if (!seen) begin errors++; $display("FAIL single_ack_timeout got=none want=ack"); end
        if (ack !== 4'b0001) begin errors++; $display("FAIL single_ack got=%b want=0001", ack); end
        if (bad) begin errors++; $display("FAIL single_data_stable got=changed want=a55a"); end
        req = '0;
        @(negedge clk);
        checks += 3;
        if (ack !== '0)   begin errors++; $display("FAIL single_ack_pulse got=%b want=0", ack); end
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall got=%b want=0", busy); end
        if (m_cap !== 16'hA55A) begin errors++; $display("FAIL single_serial got=%h want=a55a", m_cap); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp [5];
        exp[0] = 4'b0001; exp[1] = 4'b0010; exp[2] = 4'b0100; exp[3] = 4'b1000; exp[4] = 4'b0001;
        do_reset();
        model_en = 1'b1;
        req_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        req = 4'b1111;
        wait_acks(5, 400);
        req = '0;
        checks++;
        if (ngot != 5) begin errors++; $display("FAIL rr_ack_count got=%0d want=5", ngot); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got[i] !== exp[i]) begin errors++; $display("FAIL rr_order[%0d] got=%b want=%b", i, got[i], exp[i]); end
        end
        @(negedge clk);
    endtask

    task automatic test_wrap_skip();
        do_reset();
        model_en = 1'b1;
        req_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        req = 4'b0100;
        wait_acks(1, 100);
        checks++;
        if (ngot != 1 || got[0] !== 4'b0100) begin errors++; $display("FAIL wrap_first got=%b want=0100", got[0]); end
        req = 4'b0101;
        wait_acks(2, 200);
        req = '0;
        checks += 2;
        if (ngot != 2 || got[0] !== 4'b0001) begin errors++; $display("FAIL wrap_to_0 got=%b want=0001", got[0]); end
        if (ngot != 2 || got[1] !== 4'b0100) begin errors++; $display("FAIL wrap_then_2 got=%b want=0100", got[1]); end
        @(negedge clk);
    endtask

    task automatic test_timeouts();
        int   first;
        logic sawack;
        do_reset();
        model_en = 1'b0;
        req_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        req = 4'b0010;
        first = -1; sawack = 1'b0;
        for (int i = 1; i <= 70 && first < 0; i++) begin
            @(negedge clk);
            if (ack != '0) sawack = 1'b1;
            if (timeout_err) first = i;
        end
        checks += 4;
        if (first != TO + 1) begin errors++; $display("FAIL start_to_cycle got=%0d want=%0d", first, TO + 1); end
        if (tx_start !== 1'b0) begin errors++; $display("FAIL start_to_txstart got=%b want=0", tx_start); end
        if (busy !== 1'b0) begin errors++; $display("FAIL start_to_busy got=%b want=0", busy); end
        if (sawack) begin errors++; $display("FAIL start_to_noack got=ack want=none"); end
        req = 4'b0110;
        @(negedge clk);
        checks += 3;
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL start_to_pulse got=%b want=0", timeout_err); end
        if (grant_id !== 3'd2) begin errors++; $display("FAIL start_to_next got=%0d want=2", grant_id); end
        if (tx_data !== 16'h3333) begin errors++; $display("FAIL start_to_next_data got=%h want=3333", tx_data); end
        f_state = 2'd2;
        first = -1; sawack = 1'b0;
        for (int i = 1; i <= 70 && first < 0; i++) begin
            @(negedge clk);
            if (ack != '0) sawack = 1'b1;
            if (timeout_err) first = i;
        end
        req = '0; f_state = 2'd0;
        checks += 2;
        if (first != TO + 1) begin errors++; $display("FAIL done_to_cycle got=%0d want=%0d", first, TO + 1); end
        if (sawack) begin errors++; $display("FAIL done_to_noack got=ack want=none"); end
        @(negedge clk);

        do_reset();
        req = 4'b0001;
        @(negedge clk);
        f_state = 2'd2;
        first = -1; sawack = 1'b0;
        for (int j = 1; j <= TO; j++) begin
            @(negedge clk);
            if (ack != '0) sawack = 1'b1;
            if (timeout_err) first = j;
            if (j == TO) f_done = 1'b1;
        end
        @(negedge clk);
        checks += 3;
        if (ack !== 4'b0001) begin errors++; $display("FAIL prio_ack got=%b want=0001", ack); end
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL prio_no_timeout got=%b want=0", timeout_err); end
        if (sawack || first >= 0) begin errors++; $display("FAIL prio_early got=ack%b/to%0d want=none", sawack, first); end
        f_done = 1'b0; req = '0; f_state = 2'd0;
        @(negedge clk);
        checks += 2;
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL prio_late_to got=%b want=0", timeout_err); end
        if (busy !== 1'b0) begin errors++; $display("FAIL prio_busy got=%b want=0", busy); end
    endtask

    task automatic test_async_reset();
        do_reset();
        model_en = 1'b0;
        req_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        req = 4'b0100;
        @(negedge clk);
        checks++;
        if (grant_id !== 3'd2) begin errors++; $display("FAIL areset_pre_grant got=%0d want=2", grant_id); end
        f_state = 2'd2;
        @(negedge clk); @(negedge clk); @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks += 5;
        if (busy !== 1'b0)      begin errors++; $display("FAIL areset_busy got=%b want=0", busy); end
        if (tx_data !== 16'h0)  begin errors++; $display("FAIL areset_data got=%h want=0", tx_data); end
        if (grant_id !== 3'd0)  begin errors++; $display("FAIL areset_grant got=%0d want=0", grant_id); end
        if (tx_start !== 1'b0)  begin errors++; $display("FAIL areset_start got=%b want=0", tx_start); end
        if (ack !== '0 || timeout_err !== 1'b0) begin errors++; $display("FAIL areset_pulses got=%b/%b want=0/0", ack, timeout_err); end
        f_state = 2'd0;
        req = 4'b0110;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks += 3;
        if (grant_id !== 3'd1) begin errors++; $display("FAIL areset_regrant got=%0d want=1", grant_id); end
        if (tx_start !== 1'b1) begin errors++; $display("FAIL areset_restart got=%b want=1", tx_start); end
        if (tx_data !== 16'h2222) begin errors++; $display("FAIL areset_redata got=%h want=2222", tx_data); end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap_skip();
        test_timeouts();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
